// File: rtl/deser8_1_pkg.sv
// Shared constants for the 8-bit serial-to-parallel collector.
package deser8_1_pkg;
  localparam int   WORD_W  = 8;
  localparam int   IDX_W   = 3;
  localparam logic ST_FILL = 1'b0;
  localparam logic ST_FULL = 1'b1;
endpackage

// File: rtl/decode3_8.sv
// 3-bit index to one-hot 8-bit write enable; all zeros when en is low.
module decode3_8 (
  input  logic       en,
  input  logic [2:0] idx,
  output logic [7:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/dff.sv
// Generic D flip-flop cell with synchronous active-high reset to zero and load enable.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/deser8_1.sv
// Serial-to-parallel collector: steers accepted bits into an 8-bit word and
// presents the completed word on a valid/ready output.
module deser8_1
  import deser8_1_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_bit,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  count
);
  logic              state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] wr_sel;
  logic              wr_en;
  logic              accept;

  assign accept = in_valid && in_ready;
  // count is always 0 in FULL, so a hand-off write lands at the first slot.
  assign idx    = LSB_FIRST ? cnt_q : (3'd7 - cnt_q);

  dff #(.W(1))     u_state (.clk(clk), .rst(rst), .en(1'b1), .d(state_d), .q(state_q));
  dff #(.W(IDX_W)) u_cnt   (.clk(clk), .rst(rst), .en(1'b1), .d(cnt_d),   .q(cnt_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (flush) begin
          cnt_d = '0;
        end else if (accept) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = ST_FULL;
        end
      end
      default: begin
        // flush is ignored here so a complete word is never dropped.
        if (out_ready) begin
          state_d = ST_FILL;
          if (accept) begin
            wr_en = 1'b1;
            cnt_d = 3'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_FULL);
    in_ready  = (state_q == ST_FILL) ? 1'b1 : out_ready;
  end

  decode3_8 u_dec (.en(wr_en), .idx(idx), .onehot(wr_sel));

  for (genvar i = 0; i < WORD_W; i++) begin : g_bit
    dff #(.W(1)) u_bit (.clk(clk), .rst(rst), .en(wr_sel[i]), .d(in_bit), .q(out_word[i]));
  end

  assign count = cnt_q;
endmodule

// File: doc/deser8_1.md
Name: deser8_1

Overview:
- Serial-to-parallel collector: the write-side counterpart to the 8:1 bit selector.
- Accepts one bit per handshake and steers it into bit position `cnt` of an 8-bit word using a 3-to-8 write-enable decode.
- Presents the completed word on a valid/ready output.
- Used wherever a bit stream produced by a selector-driven serializer must be reassembled into a byte.

Parameters:
- LSB_FIRST, 1: 1 = first accepted bit lands in out_word[0], ascending; 0 = first bit lands in out_word[7], descending.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_bit  input  1  serial data bit
- in_valid  input  1  in_bit is valid this cycle
- in_ready  output  1  block can accept in_bit this cycle
- flush  input  1  synchronous abort of a partially filled word
- out_word  output  8  assembled word
- out_valid  output  1  out_word holds a complete word
- out_ready  input  1  downstream accepts out_word this cycle
- count  output  3  number of bits held in the current partial word (0..7)

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - out_word = 8'h00, out_valid = 0, count = 0.
  - State = FILL; in_ready = 1 in the first cycle after reset.
- Bit acceptance:
  - A bit is accepted when in_valid && in_ready on a rising edge.
- Write index:
  - idx = count when LSB_FIRST = 1; idx = 7 - count otherwise.
  - Decode idx to a one-hot write enable; only out_word[idx] is written, all other bits hold.
- States:
  - FILL: out_valid = 0, in_ready = 1.
    - On accept, write the bit and increment count.
    - When count = 7 and a bit is accepted, go to FULL and wrap count to 0.
  - FULL: out_valid = 1, in_ready = out_ready (pass-through backpressure).
    - out_ready = 0: hold out_word and stay in FULL; in_valid is ignored.
    - out_ready = 1, no accept: go to FILL.
    - out_ready = 1 and accept in the same cycle: word handed off; the new bit is written to idx for count = 0; go to FILL with count = 1.
- Stale bits:
  - Bits of out_word not yet overwritten in FILL keep their previous values.
  - Downstream may only sample out_word while out_valid = 1.
- Latency:
  - out_valid rises on the edge that accepts the 8th bit, i.e. visible one cycle after the 8th bit is presented.
  - Sustained throughput: 1 bit/cycle with zero bubbles if out_ready is held high.
- flush:
  - In FILL: count is set to 0 and the same-cycle in_bit is discarded; out_word is not cleared.
  - In FULL: ignored; a complete word is never dropped.
- Priority: rst > flush > accept.
- Mid-operation rst: the partial word is lost; state, outputs and count return to their reset values on that edge.
- X-safety: in_bit is not sampled unless in_valid && in_ready.

Decomposition:
- Shared package/include:
  - State encoding localparams: ST_FILL = 1'b0, ST_FULL = 1'b1.
  - Word-width constant: 8.
  - Index width: 3.
- Sub-module decode3_8 (3-bit index to one-hot 8-bit write enable), reusable by register-file write-select logic.
- State, count and word bits are built from the existing dff cell.

Test Plan:
- Reset then feed 1,0,1,1,0,0,1,0 on 8 consecutive cycles, out_ready = 1, LSB_FIRST = 1 -> out_valid = 1 for exactly one cycle with out_word = 8'h4D; count returns to 0.
- Same stream with LSB_FIRST = 0 -> out_word = 8'hB2.
- Complete a word with out_ready = 0 for 5 cycles while in_valid = 1 -> in_ready = 0, out_word is stable, no bits are accepted; first bit after out_ready = 1 lands in the next word with count = 1.
- Back-to-back streams 8'hFF then 8'h00 with out_ready tied high -> two out_valid pulses exactly 8 cycles apart, no lost or duplicated bit.
- Accept 3 bits, assert flush together with in_valid -> count = 0; the next 8 bits form a clean word matching the sent pattern.
- Accept 5 bits, assert rst -> next cycle count = 0, out_valid = 0, out_word = 8'h00; rst and flush asserted in the same cycle behave as rst.
